ro_edge_counter: RTL

Measurement stage directly downstream of the NOR-chain ring oscillator. It enables the oscillator and waits a settle interval for the ring to start up. It then counts rising edges of the oscillator output over a programmable window of system-clock cycles and reports the count, which is the digital V/T sensor code. It also drives the oscillator's enable and select inputs and gates them off whenever no measurement is running.

---
 rtl/ro_edge_counter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/ro_edge_counter.sv
// Ring-oscillator measurement stage: enables the ring, waits for it to settle, then counts
// synchronized rising edges over a programmable window of clock cycles (the V/T sensor code).
module ro_edge_counter #(
    parameter int WINDOW_W      = 16,
    parameter int COUNT_W       = 16,
    parameter int SETTLE_CYCLES = 8
) (
    input  logic                i_Clk,
    input  logic                i_Reset,
    input  logic                i_Start,
    input  logic [WINDOW_W-1:0] i_Window,
    input  logic                i_RO_out,
    output logic                o_RO_Enable,
    output logic                o_RO_Sel,
    output logic                o_Busy,
    output logic                o_Done,
    output logic [COUNT_W-1:0]  o_Count,
    output logic                o_Overflow
);

    typedef enum logic [1:0] {IDLE, SETTLE, COUNT, DONE} state_t;

    localparam logic [7:0]         SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [COUNT_W-1:0] COUNT_MAX   = '1;

    state_t              state;
    state_t              next_state;
    logic                s1, s2, s3;
    logic                edge_det;
    logic [WINDOW_W-1:0] win_q;
    logic [WINDOW_W-1:0] win_cnt;
    logic [7:0]          settle_cnt;
    logic [COUNT_W-1:0]  edge_cnt;
    logic [COUNT_W-1:0]  cnt_nxt;
    logic                edge_ovf;
    logic                ovf_nxt;

    // Flops preset high to match the idle-high ring, so enabling it never looks like an edge.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
        end else begin
            s1 <= i_RO_out;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign edge_det = s2 & ~s3;

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:   if (i_Start) next_state = SETTLE;
            SETTLE: if (settle_cnt == SETTLE_LAST) next_state = (win_q != '0) ? COUNT : DONE;
            COUNT:  if (win_cnt == WINDOW_W'(1)) next_state = DONE;
            DONE:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Saturating edge counter; the next value also feeds the result register so an edge
    // in the final window cycle is not lost.
    always_comb begin
        cnt_nxt = edge_cnt;
        ovf_nxt = edge_ovf;
        if (state == COUNT && edge_det) begin
            if (edge_cnt == COUNT_MAX) begin
                ovf_nxt = 1'b1;
            end else begin
                cnt_nxt = edge_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            win_q      <= '0;
            win_cnt    <= '0;
            settle_cnt <= '0;
            edge_cnt   <= '0;
            edge_ovf   <= 1'b0;
            o_Count    <= '0;
            o_Overflow <= 1'b0;
        end else begin
            if (state == IDLE && i_Start) begin
                win_q      <= i_Window;
                settle_cnt <= '0;
                edge_cnt   <= '0;
                edge_ovf   <= 1'b0;
            end else begin
                edge_cnt <= cnt_nxt;
                edge_ovf <= ovf_nxt;
            end
            if (state == SETTLE) begin
                settle_cnt <= settle_cnt + 1'b1;
                win_cnt    <= win_q;
            end
            if (state == COUNT) begin
                win_cnt <= win_cnt - 1'b1;
            end
            if (state != DONE && next_state == DONE) begin
                o_Count    <= cnt_nxt;
                o_Overflow <= ovf_nxt;
            end
        end
    end

    always_comb begin
        o_RO_Enable = (state == SETTLE) || (state == COUNT);
        o_RO_Sel    = (state == SETTLE) || (state == COUNT);
        o_Busy      = (state != IDLE);
        o_Done      = (state == DONE);
    end

endmodule
